// File: rtl/meh_controller_p.sv
`default_nettype none
// ============================================================================
//  Module   : meh_controller_p
//  Purpose  : Microcoded fetch/decode/execute sequencer for the MEH16
//             datapath. Drives the 13-bit control word, ALU op select and
//             A-register op select from the current stage and the opcode
//             fields. RAM stages stall on mem_ready_i; NOARG/HALT parks the
//             core in stage 7 until reset.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             ir_opcode_i       - opcode latched in IR
//             ram_opcode_i      - opcode field on the RAM data bus
//             ram_arg_i         - argument field on the RAM data bus
//             flags_i           - {S, C, Z}
//             mem_ready_i       - RAM access completes this cycle
//             ctrl_o            - control word (ALU_EN .. IR_LOAD)
//             alu_op_o, a_op_o  - ALU / A-register operation selects
//             stage_o, halted_o - current stage, high in HALT stage
//  Revision : 1.0 - initial release
// ============================================================================
module meh_controller_p #(
   parameter int               ARG_W    = 12,
   parameter logic [ARG_W-1:0] HALT_ARG = {ARG_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       ir_opcode_i,
   input  logic [3:0]       ram_opcode_i,
   input  logic [ARG_W-1:0] ram_arg_i,
   input  logic [2:0]       flags_i,
   input  logic             mem_ready_i,
   output logic [12:0]      ctrl_o,
   output logic [2:0]       alu_op_o,
   output logic [2:0]       a_op_o,
   output logic [2:0]       stage_o,
   output logic             halted_o
);

   // Control word bit positions
   localparam int c_ALU_EN   = 12;
   localparam int c_RAM_EN   = 11;
   localparam int c_MAR_LOAD = 10;
   localparam int c_RAM_LOAD = 9;
   localparam int c_A_EN     = 8;
   localparam int c_A_LOAD   = 7;
   localparam int c_B_EN     = 6;
   localparam int c_B_LOAD   = 5;
   localparam int c_PC_EN    = 4;
   localparam int c_PC_LOAD  = 3;
   localparam int c_PC_INC   = 2;
   localparam int c_IR_EN    = 1;
   localparam int c_IR_LOAD  = 0;

   // Bits that remain asserted while a RAM stage waits; all strobes drop.
   localparam logic [12:0] c_HOLD_MASK = 13'h0B52;

   localparam logic [3:0] c_OP_NOARG = 4'd0;
   localparam logic [3:0] c_OP_LOADA = 4'd1;
   localparam logic [3:0] c_OP_LOADB = 4'd2;
   localparam logic [3:0] c_OP_STORE = 4'd3;
   localparam logic [3:0] c_OP_JMP   = 4'd12;
   localparam logic [3:0] c_OP_JMPZ  = 4'd13;
   localparam logic [3:0] c_OP_JMPC  = 4'd14;
   localparam logic [3:0] c_OP_JMPS  = 4'd15;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXEC2   = 3'd2,
      ST_EXEC3   = 3'd3,
      ST_ALU     = 3'd4,
      ST_UNUSED5 = 3'd5,
      ST_UNUSED6 = 3'd6,
      ST_HALT    = 3'd7
   } stage_e;

   stage_e      stage_q, stage_d;
   logic [12:0] w_ctrl;
   logic [2:0]  w_alu_op;
   logic [2:0]  w_a_op;
   logic        w_ram_stage;
   logic        w_halted;

   always_comb begin
      stage_d     = stage_q;
      w_ctrl      = '0;
      w_alu_op    = '0;
      w_a_op      = '0;
      w_ram_stage = 1'b0;
      w_halted    = 1'b0;

      case (stage_q)
         ST_FETCH: begin
            w_ctrl[c_PC_EN]    = 1'b1;
            w_ctrl[c_MAR_LOAD] = 1'b1;
            stage_d            = ST_DECODE;
         end

         ST_DECODE: begin
            w_ram_stage       = 1'b1;
            w_ctrl[c_RAM_EN]  = 1'b1;
            w_ctrl[c_IR_LOAD] = 1'b1;
            case (ram_opcode_i)
               c_OP_NOARG: begin
                  if (ram_arg_i == HALT_ARG) begin
                     // PC stays on the HALT word
                     stage_d = ST_HALT;
                  end else if (ram_arg_i == ARG_W'(7)) begin
                     w_ctrl[c_PC_INC] = 1'b1;
                     stage_d          = ST_EXEC2;
                  end else begin
                     w_ctrl[c_PC_INC] = 1'b1;
                     // Unknown sub-ops execute as NOOP (a_op = 0)
                     if (ram_arg_i >= ARG_W'(1) && ram_arg_i <= ARG_W'(6))
                        w_a_op = ram_arg_i[2:0];
                     stage_d = ST_FETCH;
                  end
               end
               c_OP_JMP: begin
                  w_ctrl[c_PC_LOAD] = 1'b1;
                  stage_d           = ST_FETCH;
               end
               c_OP_JMPZ, c_OP_JMPC, c_OP_JMPS: begin
                  // opcode 13/14/15 selects flag bit 0/1/2
                  if (flags_i[ram_opcode_i[1:0] - 2'd1])
                     w_ctrl[c_PC_LOAD] = 1'b1;
                  else
                     w_ctrl[c_PC_INC]  = 1'b1;
                  stage_d = ST_FETCH;
               end
               default: begin
                  w_ctrl[c_PC_INC] = 1'b1;
                  stage_d          = ST_EXEC2;
               end
            endcase
         end

         ST_EXEC2: begin
            if (ir_opcode_i == c_OP_NOARG) begin
               // MOVBA
               w_ctrl[c_B_EN]   = 1'b1;
               w_ctrl[c_A_LOAD] = 1'b1;
               stage_d          = ST_FETCH;
            end else begin
               w_ctrl[c_IR_EN]    = 1'b1;
               w_ctrl[c_MAR_LOAD] = 1'b1;
               stage_d            = ST_EXEC3;
            end
         end

         ST_EXEC3: begin
            stage_d = ST_FETCH;
            if (ir_opcode_i == c_OP_LOADA) begin
               w_ram_stage      = 1'b1;
               w_ctrl[c_RAM_EN] = 1'b1;
               w_ctrl[c_A_LOAD] = 1'b1;
            end else if (ir_opcode_i == c_OP_LOADB) begin
               w_ram_stage      = 1'b1;
               w_ctrl[c_RAM_EN] = 1'b1;
               w_ctrl[c_B_LOAD] = 1'b1;
            end else if (ir_opcode_i == c_OP_STORE) begin
               w_ram_stage        = 1'b1;
               w_ctrl[c_A_EN]     = 1'b1;
               w_ctrl[c_RAM_LOAD] = 1'b1;
            end else if (ir_opcode_i >= 4'd4 && ir_opcode_i <= 4'd11) begin
               w_ram_stage      = 1'b1;
               w_ctrl[c_RAM_EN] = 1'b1;
               w_ctrl[c_B_LOAD] = 1'b1;
               stage_d          = ST_ALU;
            end
         end

         ST_ALU: begin
            w_ctrl[c_ALU_EN] = 1'b1;
            w_ctrl[c_A_LOAD] = 1'b1;
            w_alu_op         = 3'(ir_opcode_i - 4'd4);
            stage_d          = ST_FETCH;
         end

         ST_HALT: begin
            w_halted = 1'b1;
         end

         default: begin
            // Unreachable stages 5/6 recover through FETCH
            stage_d = ST_FETCH;
         end
      endcase

      // RAM wait: hold the stage, keep enables, drop every strobe
      if (w_ram_stage && !mem_ready_i) begin
         w_ctrl  = w_ctrl & c_HOLD_MASK;
         w_a_op  = '0;
         stage_d = stage_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stage_q <= ST_FETCH;
      else
         stage_q <= stage_d;
   end

   assign ctrl_o   = rst ? '0 : w_ctrl;
   assign alu_op_o = rst ? '0 : w_alu_op;
   assign a_op_o   = rst ? '0 : w_a_op;
   assign halted_o = rst ? 1'b0 : w_halted;
   assign stage_o  = stage_q;

endmodule
`default_nettype wire

// File: tb/tb_meh_controller_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_meh_controller_p
//  Purpose  : Bench for meh_controller_p. Each instruction is expanded into
//             its list of micro-steps; a driver walks that list with random
//             memory waits and pushes the expected outputs per cycle into a
//             queue which a separate monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_meh_controller_p;

   logic        clk;
   logic        rst;
   logic [3:0]  ir_opcode;
   logic [3:0]  ram_opcode;
   logic [11:0] ram_arg;
   logic [2:0]  flags;
   logic        mem_ready;
   logic [12:0] ctrl;
   logic [2:0]  alu_op;
   logic [2:0]  a_op;
   logic [2:0]  stage;
   logic        halted;

   meh_controller_p #(.ARG_W(12), .HALT_ARG(12'hFFF)) dut (
      .clk         (clk),
      .rst         (rst),
      .ir_opcode_i (ir_opcode),
      .ram_opcode_i(ram_opcode),
      .ram_arg_i   (ram_arg),
      .flags_i     (flags),
      .mem_ready_i (mem_ready),
      .ctrl_o      (ctrl),
      .alu_op_o    (alu_op),
      .a_op_o      (a_op),
      .stage_o     (stage),
      .halted_o    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  stg;
      logic        ram;
      logic [12:0] word;
      logic [2:0]  alu;
      logic [2:0]  aop;
   } step_t;

   typedef struct packed {
      logic [12:0] ctrl;
      logic [2:0]  alu;
      logic [2:0]  aop;
      logic [2:0]  stg;
      logic        halted;
      logic        chk_stg;
   } exp_t;

   // Enables that survive a memory wait
   localparam logic [12:0] c_HOLD = 13'h0B52;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic step_t mk(input int stg, input bit ram, input logic [12:0] word,
                                input int alu, input int aop);
      step_t s;
      s.stg  = 3'(stg);
      s.ram  = ram;
      s.word = word;
      s.alu  = 3'(alu);
      s.aop  = 3'(aop);
      return s;
   endfunction

   task automatic drive_cycle(input logic r, input logic [3:0] iro, input logic [3:0] rop,
                              input logic [11:0] rarg, input logic [2:0] fl,
                              input logic rdy, input exp_t e);
      @(posedge clk);
      #1;
      rst        = r;
      ir_opcode  = iro;
      ram_opcode = rop;
      ram_arg    = rarg;
      flags      = fl;
      mem_ready  = rdy;
      sb.push_back(e);
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e = '{ctrl: 13'h0, alu: 3'd0, aop: 3'd0, stg: 3'd0, halted: 1'b0,
               chk_stg: (i > 0)};
         drive_cycle(1'b1, 4'($urandom), 4'($urandom), 12'($urandom), 3'($urandom),
                     1'($urandom), e);
      end
   endtask

   // Runs one instruction. rdy_pct: chance of mem_ready per cycle;
   // stall3: forced waits in stage 3; halt_cyc: cycles spent halted before
   // reset; abort_at: cycle index at which reset aborts (-1 = never).
   task automatic run_instr(input logic [3:0] opc, input logic [11:0] arg,
                            input logic [2:0] fl, input int rdy_pct, input int stall3,
                            input int halt_cyc, input int abort_at);
      step_t       plan[$];
      step_t       s;
      exp_t        e;
      int          idx = 0;
      int          cyc = 0;
      int          st3 = stall3;
      logic        rdy;
      logic        taken;
      logic [2:0]  fr;
      bit          is_halt = (opc == 4'd0) && (arg == 12'hFFF);

      plan.push_back(mk(0, 0, 13'h0410, 0, 0));
      if (opc == 4'd0) begin
         if (is_halt)
            plan.push_back(mk(1, 1, 13'h0801, 0, 0));
         else if (arg == 12'd7) begin
            plan.push_back(mk(1, 1, 13'h0805, 0, 0));
            plan.push_back(mk(2, 0, 13'h00C0, 0, 0));
         end else
            plan.push_back(mk(1, 1, 13'h0805, 0, (arg >= 1 && arg <= 6) ? int'(arg) : 0));
      end else if (opc >= 4'd12) begin
         fr    = fl;
         taken = (opc == 4'd12) || fr[int'(opc) - 13];
         plan.push_back(mk(1, 1, taken ? 13'h0809 : 13'h0805, 0, 0));
      end else begin
         plan.push_back(mk(1, 1, 13'h0805, 0, 0));
         plan.push_back(mk(2, 0, 13'h0402, 0, 0));
         case (opc)
            4'd1:    plan.push_back(mk(3, 1, 13'h0880, 0, 0));
            4'd2:    plan.push_back(mk(3, 1, 13'h0820, 0, 0));
            4'd3:    plan.push_back(mk(3, 1, 13'h0300, 0, 0));
            default: plan.push_back(mk(3, 1, 13'h0820, 0, 0));
         endcase
         if (opc >= 4'd4)
            plan.push_back(mk(4, 0, 13'h1080, int'(opc) - 4, 0));
      end

      while (idx < plan.size()) begin
         if (cyc == abort_at) begin
            do_reset(1 + int'($urandom_range(0, 1)));
            return;
         end
         s   = plan[idx];
         rdy = ($urandom_range(0, 99) < rdy_pct);
         if (s.stg == 3'd3 && st3 > 0) begin
            rdy = 1'b0;
            st3--;
         end
         e.ctrl    = (s.ram && !rdy) ? (s.word & c_HOLD) : s.word;
         e.aop     = (s.ram && !rdy) ? 3'd0 : s.aop;
         e.alu     = s.alu;
         e.stg     = s.stg;
         e.halted  = 1'b0;
         e.chk_stg = 1'b1;
         drive_cycle(1'b0,
                     (s.stg >= 3'd2) ? opc : 4'($urandom),
                     (s.stg == 3'd1) ? opc : 4'($urandom),
                     (s.stg == 3'd1) ? arg : 12'($urandom),
                     (s.stg == 3'd1) ? fl  : 3'($urandom),
                     rdy, e);
         if (!s.ram || rdy) idx++;
         cyc++;
      end

      if (is_halt) begin
         for (int i = 0; i < halt_cyc; i++) begin
            e = '{ctrl: 13'h0, alu: 3'd0, aop: 3'd0, stg: 3'd7, halted: 1'b1, chk_stg: 1'b1};
            drive_cycle(1'b0, 4'($urandom), 4'($urandom), 12'($urandom), 3'($urandom),
                        1'($urandom), e);
         end
         do_reset(2);
      end
   endtask

   task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
      end
   endtask

   // Monitor: one expected entry per cycle, sampled mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("ctrl",   ctrl,          e.ctrl);
         chk("alu_op", 13'(alu_op),   13'(e.alu));
         chk("a_op",   13'(a_op),     13'(e.aop));
         chk("halted", 13'(halted),   13'(e.halted));
         if (e.chk_stg)
            chk("stage", 13'(stage), 13'(e.stg));
      end
   end

   initial begin
      logic [3:0]  opc;
      logic [11:0] arg;
      int          sel;

      rst        = 1'b1;
      ir_opcode  = '0;
      ram_opcode = '0;
      ram_arg    = '0;
      flags      = '0;
      mem_ready  = 1'b0;

      // Directed scenarios
      do_reset(2);
      run_instr(4'd4, 12'h123, 3'b000, 100, 0, 0, -1);   // ADD
      run_instr(4'd1, 12'h055, 3'b000, 100, 3, 0, -1);   // LOADA, 3 waits
      run_instr(4'd13, 12'h010, 3'b001, 100, 0, 0, -1);  // JMPZ taken
      run_instr(4'd13, 12'h010, 3'b000, 100, 0, 0, -1);  // JMPZ not taken
      run_instr(4'd0, 12'd1, 3'b000, 100, 0, 0, -1);     // INC
      run_instr(4'd0, 12'd7, 3'b000, 100, 0, 0, -1);     // MOVBA
      run_instr(4'd3, 12'h0AA, 3'b000, 60, 2, 0, -1);    // STORE with waits
      run_instr(4'd0, 12'hFFF, 3'b000, 100, 0, 20, -1);  // HALT, then reset

      // Random instruction stream
      for (int n = 0; n < 300; n++) begin
         opc = 4'($urandom);
         arg = 12'($urandom);
         if (opc == 4'd0) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 8)       arg = 12'(sel);
            else if (sel == 8) arg = 12'hFFF;
         end
         run_instr(opc, arg, 3'($urandom), 70, 0, int'($urandom_range(1, 6)),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1);
      end

      for (int w = 0; w < 5 && sb.size() > 0; w++)
         @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
